// File: rtl/vec_element_counter.sv
// Vector element counter: walks element indices vstart..vl-1, LANES per cycle, for vector decode.
// Latency: first group one cycle after de_en; done in the cycle after the last accepted group.
// Backpressure: stall freezes everything; busy_ex holds only the final group until execute accepts it.
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   vstart, vl           CSR first element index and vector length
//   de_en                start a new op (ignored while busy)
//   stall / clear        freeze this cycle / abort the op without a done pulse
//   ex_return            restart the current op from its start element
//   slide1up             element 0 handled elsewhere, count begins at max(vstart,1)
//   busy_ex              execute cannot take the final group yet
//   reverse              (VEC_COUNTER_REVERSE_EN only) walk downward, sampled at de_en
//   offset               lane-0 element index of the current group
//   lane_active          per-lane element enables
//   next_done            current group is the last one
//   done                 one-cycle completion pulse
//   busy                 op in flight
//
// Optional feature macro: VEC_COUNTER_REVERSE_EN adds the descending walk.
// CSR inputs (vstart, vl, slide1up) are expected to stay stable for the life of an op.

module vec_element_counter #(
   parameter int LANES    = 2,
   parameter int OFFSET_W = 5,
   parameter int WORD_W   = 32
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [WORD_W-1:0]   vstart,
   input  logic [WORD_W-1:0]   vl,
   input  logic                de_en,
   input  logic                stall,
   input  logic                clear,
   input  logic                ex_return,
   input  logic                slide1up,
   input  logic                busy_ex,
`ifdef VEC_COUNTER_REVERSE_EN
   input  logic                reverse,
`endif
   output logic [OFFSET_W-1:0] offset,
   output logic [LANES-1:0]    lane_active,
   output logic                next_done,
   output logic                done,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [OFFSET_W:0] LANES_O = (OFFSET_W+1)'(LANES);
   localparam logic [WORD_W:0]   VL_MAX  = (WORD_W+1)'(1) << OFFSET_W;
`ifdef VEC_COUNTER_REVERSE_EN
   localparam logic [WORD_W:0]   LANES_W = (WORD_W+1)'(LANES);
`endif

   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;

   logic [WORD_W-1:0]   start;
   logic                launch_empty;
   logic                launch;
   logic [OFFSET_W-1:0] first_offset;
   logic [OFFSET_W-1:0] step_offset;
   logic [OFFSET_W:0]   off_plus;
   logic                last_group;
   logic [WORD_W-1:0]   elem_idx;
   logic [LANES-1:0]    lane_act;

`ifdef VEC_COUNTER_REVERSE_EN
   logic                reverse_q, reverse_d;
   logic [OFFSET_W-1:0] start_q, start_d;
   logic                launch_rev;
   logic [WORD_W-1:0]   vl_minus_lanes;
`endif

   // Start element of an op. slide1up leaves element 0 to a separate path,
   // so a zero vstart is bumped to 1. An empty range (including vl=0) skips COUNT.
   always_comb begin
      start = vstart;
      if (slide1up && (vstart == '0)) begin
         start = WORD_W'(1);
      end
      launch_empty = (start >= vl);
   end

   // First group offset. Ascending ops begin at start; descending ops begin at
   // the topmost full group, never below start.
   always_comb begin
      first_offset = start[OFFSET_W-1:0];
`ifdef VEC_COUNTER_REVERSE_EN
      // A new op takes the direction from the port; a restart keeps the latched one.
      launch_rev     = (state_q == IDLE) ? reverse : reverse_q;
      vl_minus_lanes = vl - LANES_W[WORD_W-1:0];
      if (launch_rev && ({1'b0, vl} >= ({1'b0, start} + LANES_W))) begin
         first_offset = vl_minus_lanes[OFFSET_W-1:0];
      end
`endif
   end

   // Current-group evaluation: lane enables, last-group detect and next offset.
   // The sum is one bit wider than offset so the last-group compare cannot wrap.
   always_comb begin
      off_plus    = {1'b0, offset_q} + LANES_O;
      step_offset = off_plus[OFFSET_W-1:0];
      last_group  = (WORD_W'(off_plus) >= vl);
`ifdef VEC_COUNTER_REVERSE_EN
      if (reverse_q) begin
         last_group = (offset_q <= start_q);
         // Clamp the downward step so no group starts below the first element.
         if ({1'b0, offset_q} >= ({1'b0, start_q} + LANES_O)) begin
            step_offset = offset_q - LANES_O[OFFSET_W-1:0];
         end else begin
            step_offset = start_q;
         end
      end
`endif
      elem_idx = '0;
      lane_act = '0;
      for (int i = 0; i < LANES; i++) begin
         // Compare at full CSR width; offset is zero-extended so no lane wraps.
         elem_idx    = WORD_W'(offset_q) + WORD_W'(i);
         lane_act[i] = (elem_idx < vl);
`ifdef VEC_COUNTER_REVERSE_EN
         if (reverse_q && (elem_idx < WORD_W'(start_q))) begin
            lane_act[i] = 1'b0;
         end
`endif
      end
   end

   // Next-state logic. Priority: clear > ex_return > stall > normal flow.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      launch   = 1'b0;
`ifdef VEC_COUNTER_REVERSE_EN
      reverse_d = reverse_q;
      start_d   = start_q;
`endif

      if (clear) begin
         state_d  = IDLE;
         offset_d = '0;
      end else if (ex_return && (state_q != IDLE)) begin
         launch = 1'b1;
      end else if (!stall) begin
         case (state_q)
            IDLE: begin
               if (de_en) begin
                  launch = 1'b1;
               end
            end
            COUNT: begin
               if (!last_group) begin
                  offset_d = step_offset;
               end else if (!busy_ex) begin
                  // Offset stays on the last group through FINISH.
                  state_d = FINISH;
               end
            end
            FINISH: begin
               state_d  = IDLE;
               offset_d = '0;
            end
            default: begin
               state_d  = IDLE;
               offset_d = '0;
            end
         endcase
      end

      if (launch) begin
`ifdef VEC_COUNTER_REVERSE_EN
         reverse_d = launch_rev;
         start_d   = start[OFFSET_W-1:0];
`endif
         if (launch_empty) begin
            state_d  = FINISH;
            offset_d = '0;
         end else begin
            state_d  = COUNT;
            offset_d = first_offset;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         offset_q <= '0;
`ifdef VEC_COUNTER_REVERSE_EN
         reverse_q <= 1'b0;
         start_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
`ifdef VEC_COUNTER_REVERSE_EN
         reverse_q <= reverse_d;
         start_q   <= start_d;
`endif
      end
   end

   assign offset      = offset_q;
   assign busy        = (state_q != IDLE);
   assign lane_active = (state_q == COUNT) ? lane_act : '0;
   assign next_done   = (state_q == COUNT) && last_group;
   // FINISH lingers while stalled, so the pulse is deferred, not repeated.
   // An op that is flushed or restarted in FINISH never reports completion.
   assign done        = (state_q == FINISH) && !stall && !clear && !ex_return;

   // Offsets cannot represent element indices beyond 2**OFFSET_W.
   always @(posedge CLK) begin
      if (nRST && (launch || (state_q != IDLE))) begin
         assert ({1'b0, vl} <= VL_MAX)
            else $error("vec_element_counter: vl %0d exceeds 2**OFFSET_W", vl);
      end
   end

endmodule

// File: tb/tb_vec_element_counter.sv
// Bench for vec_element_counter: directed ops, expected per-cycle outputs queued up front.
// Latency: outputs compared at the falling edge whenever busy or done is high.
// Backpressure: stall and busy_ex are driven directly by the stimulus.

module tb_vec_element_counter;

   localparam int LANES    = 2;
   localparam int OFFSET_W = 5;
   localparam int WORD_W   = 32;

   logic                CLK = 1'b0;
   logic                nRST;
   logic [WORD_W-1:0]   vstart;
   logic [WORD_W-1:0]   vl;
   logic                de_en, stall, clear, ex_return, slide1up, busy_ex;
`ifdef VEC_COUNTER_REVERSE_EN
   logic                reverse;
`endif
   logic [OFFSET_W-1:0] offset;
   logic [LANES-1:0]    lane_active;
   logic                next_done, done, busy;

   always #5 CLK = ~CLK;

   vec_element_counter #(
      .LANES   (LANES),
      .OFFSET_W(OFFSET_W),
      .WORD_W  (WORD_W)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .vstart     (vstart),
      .vl         (vl),
      .de_en      (de_en),
      .stall      (stall),
      .clear      (clear),
      .ex_return  (ex_return),
      .slide1up   (slide1up),
      .busy_ex    (busy_ex),
`ifdef VEC_COUNTER_REVERSE_EN
      .reverse    (reverse),
`endif
      .offset     (offset),
      .lane_active(lane_active),
      .next_done  (next_done),
      .done       (done),
      .busy       (busy)
   );

   typedef struct {
      string               name;
      logic [OFFSET_W-1:0] off;
      logic [LANES-1:0]    la;
      logic                nd;
      logic                dn;
      logic                by;
   } exp_t;

   exp_t  sb[$];
   int    tests = 0;
   int    fails = 0;
   bit    mon_en = 1'b0;
   bit    idle_chk = 1'b0;
   bit    final_chk = 1'b0;
   string idle_name = "";

   // Monitor: every active output cycle consumes one queued expectation.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (busy || done) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got off=%0d la=%b nd=%b done=%b busy=%b, expected no active output",
                        offset, lane_active, next_done, done, busy);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({offset, lane_active, next_done, done, busy} !== {e.off, e.la, e.nd, e.dn, e.by}) begin
                  fails++;
                  $display("FAIL %s: got off=%0d la=%b nd=%b done=%b busy=%b, expected off=%0d la=%b nd=%b done=%b busy=%b",
                           e.name, offset, lane_active, next_done, done, busy, e.off, e.la, e.nd, e.dn, e.by);
               end
            end
         end else if (idle_chk) begin
            tests++;
            if ({offset, lane_active, next_done, done, busy} !== '0) begin
               fails++;
               $display("FAIL %s: got off=%0d la=%b nd=%b done=%b busy=%b, expected all zero",
                        idle_name, offset, lane_active, next_done, done, busy);
            end
         end
         if (final_chk) begin
            tests++;
            if (sb.size() != 0) begin
               fails++;
               $display("FAIL leftover_expectations: got %0d still queued, expected 0", sb.size());
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push(input string name, input int off, input int la,
                       input logic nd, input logic dn, input logic by);
      exp_t e;
      e.name = name;
      e.off  = off[OFFSET_W-1:0];
      e.la   = la[LANES-1:0];
      e.nd   = nd;
      e.dn   = dn;
      e.by   = by;
      sb.push_back(e);
   endtask

   // Pulse de_en for one edge; returns in the first cycle after it.
   task automatic launch(input int vs, input int len);
      vstart = WORD_W'(vs);
      vl     = WORD_W'(len);
      de_en  = 1'b1;
      step(1);
      de_en  = 1'b0;
   endtask

   task automatic idle_check(input string name);
      idle_name = name;
      idle_chk  = 1'b1;
      step(1);
      idle_chk  = 1'b0;
   endtask

   initial begin
      nRST = 1'b0; vstart = '0; vl = '0;
      de_en = 1'b0; stall = 1'b0; clear = 1'b0; ex_return = 1'b0;
      slide1up = 1'b0; busy_ex = 1'b0;
`ifdef VEC_COUNTER_REVERSE_EN
      reverse = 1'b0;
`endif
      step(2);
      mon_en = 1'b1;
      idle_check("reset_state");
      nRST = 1'b1;
      step(1);

      // vl=5 from 0: groups 0,2,4 then done
      push("t1_g0", 0, 2'b11, 0, 0, 1);
      push("t1_g2", 2, 2'b11, 0, 0, 1);
      push("t1_g4", 4, 2'b01, 1, 0, 1);
      push("t1_done", 4, 2'b00, 0, 1, 1);
      launch(0, 5);
      step(4);
      idle_check("t1_idle_after");

      // empty ranges go straight to FINISH
      push("t2_vl0_done", 0, 2'b00, 0, 1, 1);
      launch(0, 0);
      step(1);
      idle_check("t2_vl0_idle");
      push("t2_vs6_done", 0, 2'b00, 0, 1, 1);
      launch(6, 4);
      step(1);
      idle_check("t2_vs6_idle");

      // slide1up starts at element 1
      slide1up = 1'b1;
      push("t3_g1", 1, 2'b11, 0, 0, 1);
      push("t3_g3", 3, 2'b01, 1, 0, 1);
      push("t3_done", 3, 2'b00, 0, 1, 1);
      launch(0, 4);
      step(3);
      slide1up = 1'b0;
      idle_check("t3_idle");

      // stall at offset 4 for 3 cycles, then stall across FINISH
      push("t4_g0", 0, 2'b11, 0, 0, 1);
      push("t4_g2", 2, 2'b11, 0, 0, 1);
      for (int i = 0; i < 4; i++) push("t4_g4_hold", 4, 2'b11, 0, 0, 1);
      push("t4_g6", 6, 2'b11, 1, 0, 1);
      push("t4_fin_stall", 6, 2'b00, 0, 0, 1);
      push("t4_fin_stall", 6, 2'b00, 0, 0, 1);
      push("t4_done", 6, 2'b00, 0, 1, 1);
      launch(0, 8);
      step(2);
      stall = 1'b1;
      step(3);
      stall = 1'b0;
      step(2);
      stall = 1'b1;
      step(2);
      stall = 1'b0;
      step(1);
      idle_check("t4_idle");

      // busy_ex holds the final group
      push("bx_g0", 0, 2'b11, 0, 0, 1);
      for (int i = 0; i < 3; i++) push("bx_g2_hold", 2, 2'b11, 1, 0, 1);
      push("bx_done", 2, 2'b00, 0, 1, 1);
      launch(0, 4);
      step(1);
      busy_ex = 1'b1;
      step(2);
      busy_ex = 1'b0;
      step(2);
      idle_check("bx_idle");

      // misaligned vstart=1, vl=6: groups 1,3,5
      push("mis_g1", 1, 2'b11, 0, 0, 1);
      push("mis_g3", 3, 2'b11, 0, 0, 1);
      push("mis_g5", 5, 2'b01, 1, 0, 1);
      push("mis_done", 5, 2'b00, 0, 1, 1);
      launch(1, 6);
      step(4);
      idle_check("mis_idle");

      // clear at offset 2: no done
      push("t5_clr_g0", 0, 2'b11, 0, 0, 1);
      push("t5_clr_g2", 2, 2'b11, 0, 0, 1);
      launch(0, 8);
      step(1);
      clear = 1'b1;
      step(1);
      idle_check("t5_after_clear");
      clear = 1'b0;

      // ex_return at offset 4 with vstart=2 reloads offset 2
      push("t5_exr_g2", 2, 2'b11, 0, 0, 1);
      push("t5_exr_g4", 4, 2'b11, 0, 0, 1);
      push("t5_exr_reload", 2, 2'b11, 0, 0, 1);
      push("t5_exr_g4b", 4, 2'b11, 0, 0, 1);
      push("t5_exr_g6", 6, 2'b11, 1, 0, 1);
      push("t5_exr_done", 6, 2'b00, 0, 1, 1);
      launch(2, 8);
      step(1);
      ex_return = 1'b1;
      step(1);
      ex_return = 1'b0;
      step(3);
      step(1);
      idle_check("t5_exr_idle");

      // reset mid-COUNT at offset 6
      push("t6_g0", 0, 2'b11, 0, 0, 1);
      push("t6_g2", 2, 2'b11, 0, 0, 1);
      push("t6_g4", 4, 2'b11, 0, 0, 1);
      push("t6_g6", 6, 2'b11, 0, 0, 1);
      launch(0, 10);
      step(3);
      nRST = 1'b0;
      step(1);
      idle_check("t6_after_reset");
      nRST = 1'b1;
      step(1);

`ifdef VEC_COUNTER_REVERSE_EN
      // descending walk vl=5: 3,1, then clamped 0
      reverse = 1'b1;
      push("rev_g3", 3, 2'b11, 0, 0, 1);
      push("rev_g1", 1, 2'b11, 0, 0, 1);
      push("rev_g0", 0, 2'b11, 1, 0, 1);
      push("rev_done", 0, 2'b00, 0, 1, 1);
      launch(0, 5);
      reverse = 1'b0;
      step(4);
      idle_check("rev_idle");
`endif

      step(2);
      final_chk = 1'b1;
      step(1);
      final_chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
